systolic_drain_collector: RTL and testbench

- Sits at the bottom edge of the systolic array and consumes its per-column en_down/data_down outputs.
- Absorbs the diagonal skew between columns using one small FIFO per column.
- Re-serialises each completed result row into a single valid/ready word stream for the NICE response path.
- It is the receiving end of the array's downward result interface.

---
 rtl/systolic_drain_collector.sv | 141 ++++++++++++++
 tb/tb_systolic_drain_collector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain_collector.sv
// Receives the systolic array's per-column en_down/data_down results, deskews them
// in one FIFO per column, and emits each completed row as a column-ordered stream.
module systolic_drain_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned COLS       = 5,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COLS-1:0]              en_down,
    input  logic [DATA_WIDTH-1:0]        data_down [COLS],
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   row_count,
    output logic [COLS-1:0]              overflow,
    output logic                         busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0]    LAST_COL = CW'(COLS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_ptr_q, col_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [COLS][DEPTH];
    logic [PTR_W-1:0]      wptr_q [COLS];
    logic [PTR_W-1:0]      wptr_d [COLS];
    logic [PTR_W-1:0]      rptr_q [COLS];
    logic [PTR_W-1:0]      rptr_d [COLS];
    logic [CNT_W-1:0]      count_q [COLS];
    logic [CNT_W-1:0]      count_d [COLS];
    logic [CNT_W-1:0]      row_count_q, row_count_d;
    logic [COLS-1:0]       overflow_q, overflow_d;
    logic [COLS-1:0]       push, pop, nonempty;
    logic [DATA_WIDTH-1:0] head;
    logic                  flush;

    assign flush = rst | clear;

    // A full FIFO still accepts a push when its head is popped on the same edge.
    always_comb begin
        push       = '0;
        pop        = '0;
        nonempty   = '0;
        overflow_d = overflow_q;
        for (int unsigned j = 0; j < COLS; j++) begin
            wptr_d[j]   = wptr_q[j];
            rptr_d[j]   = rptr_q[j];
            count_d[j]  = count_q[j];
            nonempty[j] = (count_q[j] != '0);
            pop[j]      = (state_q == SEND) && out_ready && (col_ptr_q == CW'(j));
            push[j]     = en_down[j] && ((count_q[j] != FULL_CNT) || pop[j]);
            if (en_down[j] && !push[j]) overflow_d[j] = 1'b1;
            if (push[j]) wptr_d[j] = wptr_q[j] + PTR_W'(1);
            if (pop[j])  rptr_d[j] = rptr_q[j] + PTR_W'(1);
            case ({push[j], pop[j]})
                2'b10:   count_d[j] = count_q[j] + CNT_W'(1);
                2'b01:   count_d[j] = count_q[j] - CNT_W'(1);
                default: count_d[j] = count_q[j];
            endcase
        end
        row_count_d = count_d[0];
        for (int unsigned j = 1; j < COLS; j++) begin
            if (count_d[j] < row_count_d) row_count_d = count_d[j];
        end
    end

    always_comb begin
        state_d   = state_q;
        col_ptr_d = col_ptr_q;
        case (state_q)
            IDLE: begin
                if (&nonempty) begin
                    state_d   = SEND;
                    col_ptr_d = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (col_ptr_q == LAST_COL) state_d = IDLE;
                    else                       col_ptr_d = col_ptr_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q     <= IDLE;
            col_ptr_q   <= '0;
            overflow_q  <= '0;
            row_count_q <= '0;
            for (int unsigned j = 0; j < COLS; j++) begin
                wptr_q[j]  <= '0;
                rptr_q[j]  <= '0;
                count_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_ptr_q   <= col_ptr_d;
            overflow_q  <= overflow_d;
            row_count_q <= row_count_d;
            for (int unsigned j = 0; j < COLS; j++) begin
                wptr_q[j]  <= wptr_d[j];
                rptr_q[j]  <= rptr_d[j];
                count_q[j] <= count_d[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int unsigned j = 0; j < COLS; j++) begin
                if (push[j]) mem_q[j][wptr_q[j]] <= data_down[j];
            end
        end
    end

    always_comb begin
        head = '0;
        for (int unsigned j = 0; j < COLS; j++) begin
            if (col_ptr_q == CW'(j)) head = mem_q[j][rptr_q[j]];
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? head : '0;
    assign out_last  = out_valid && (col_ptr_q == LAST_COL);
    assign row_count = row_count_q;
    assign overflow  = overflow_q;
    assign busy      = out_valid || (|nonempty);

endmodule

// File: tb/tb_systolic_drain_collector.sv
// Bench for systolic_drain_collector: directed table and scenarios plus random
// traffic, all checked against a queue-based row model.
module tb_systolic_drain_collector;

    localparam int unsigned DW    = 32;
    localparam int unsigned COLS  = 5;
    localparam int unsigned DEPTH = 8;

    logic            clk;
    logic            rst;
    logic [COLS-1:0] en_down;
    logic [DW-1:0]   din [COLS];
    logic            clear;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [3:0]      row_count;
    logic [COLS-1:0] overflow;
    logic            busy;

    systolic_drain_collector #(
        .DATA_WIDTH(DW),
        .COLS(COLS),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en_down(en_down),
        .data_down(din),
        .clear(clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .row_count(row_count),
        .overflow(overflow),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per column plus "row in flight" state.
    logic [DW-1:0]   mq [COLS][$];
    bit              msend = 0;
    int unsigned     mcol  = 0;
    logic [COLS-1:0] movf  = '0;
    logic [DW-1:0]   got [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic [COLS-1:0] en, input logic rdy, input logic flush);
        int  pc;
        bit  all_ne;
        if (flush) begin
            for (int j = 0; j < COLS; j++) mq[j].delete();
            msend = 0;
            mcol  = 0;
            movf  = '0;
            return;
        end
        all_ne = 1;
        for (int j = 0; j < COLS; j++) if (mq[j].size() == 0) all_ne = 0;
        pc = (msend && rdy) ? int'(mcol) : -1;
        if (pc >= 0) void'(mq[pc].pop_front());
        for (int j = 0; j < COLS; j++) begin
            if (en[j]) begin
                if (mq[j].size() < DEPTH) mq[j].push_back(din[j]);
                else                      movf[j] = 1'b1;
            end
        end
        if (msend) begin
            if (pc >= 0) begin
                if (mcol == COLS - 1) msend = 0;
                else                  mcol++;
            end
        end else if (all_ne) begin
            msend = 1;
            mcol  = 0;
        end
    endtask

    task automatic check_model();
        logic [31:0] ed;
        int          mn;
        bit          anyb;
        ed   = msend ? mq[mcol][0] : 32'h0;
        mn   = DEPTH;
        anyb = msend;
        for (int j = 0; j < COLS; j++) begin
            if (mq[j].size() < mn) mn = mq[j].size();
            if (mq[j].size() != 0) anyb = 1;
        end
        chk("out_valid", 32'(out_valid), 32'(msend));
        chk("out_data",  out_data, ed);
        chk("out_last",  32'(out_last), 32'(msend && (mcol == COLS - 1)));
        chk("row_count", 32'(row_count), 32'(mn));
        chk("overflow",  32'(overflow), 32'(movf));
        chk("busy",      32'(busy), 32'(anyb));
    endtask

    task automatic step(input logic [COLS-1:0] en, input logic rdy, input logic clr, input logic rs);
        en_down   = en;
        out_ready = rdy;
        clear     = clr;
        rst       = rs;
        if (out_valid && rdy && !clr && !rs) got.push_back(out_data);
        @(posedge clk);
        model_edge(en, rdy, clr | rs);
        #1;
        check_model();
    endtask

    task automatic set_row(input logic [DW-1:0] base);
        for (int j = 0; j < COLS; j++) din[j] = base + DW'(j);
    endtask

    task automatic chk_rows(input string name, input logic [DW-1:0] base, input int rows);
        chk({name, "_count"}, 32'(got.size()), 32'(rows * COLS));
        for (int k = 0; k < got.size() && k < rows * COLS; k++)
            chk(name, got[k], base + DW'((k / COLS) * 16 + (k % COLS)));
    endtask

    typedef struct {
        logic [COLS-1:0] en;
        logic            rdy;
        logic            v;
        logic [DW-1:0]   d;
        logic            last;
        logic            bsy;
    } vec_t;

    vec_t tbl [11];
    logic pat [8];

    initial begin
        tbl[0]  = '{5'b00001, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[1]  = '{5'b00010, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[2]  = '{5'b00100, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[3]  = '{5'b01000, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[4]  = '{5'b10000, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[5]  = '{5'b00000, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1};
        tbl[6]  = '{5'b00000, 1'b1, 1'b1, 32'h101, 1'b0, 1'b1};
        tbl[7]  = '{5'b00000, 1'b1, 1'b1, 32'h102, 1'b0, 1'b1};
        tbl[8]  = '{5'b00000, 1'b1, 1'b1, 32'h103, 1'b0, 1'b1};
        tbl[9]  = '{5'b00000, 1'b1, 1'b1, 32'h104, 1'b1, 1'b1};
        tbl[10] = '{5'b00000, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; clear = 1'b0; out_ready = 1'b0; en_down = '1;
        set_row(32'hDEAD0000);

        // Reset held while every column presents data: nothing may be stored.
        for (int i = 0; i < 3; i++) step(5'b11111, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  out_data, 32'h0);
        chk("rst_last",  32'(out_last), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("rst_rowcnt", 32'(row_count), 32'h0);

        // Skewed single row from the table.
        set_row(32'h100);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].rdy, 1'b0, 1'b0);
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
            chk("tbl_data",  out_data, tbl[i].d);
            chk("tbl_last",  32'(out_last), 32'(tbl[i].last));
            chk("tbl_busy",  32'(busy), 32'(tbl[i].bsy));
        end

        // Backpressure on a skewed row.
        for (int j = 0; j < COLS; j++) step(COLS'(1 << j), 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        got.delete();
        for (int i = 0; i < 8; i++) step('0, pat[i], 1'b0, 1'b0);
        chk_rows("bp_word", 32'h100, 1);
        chk("bp_idle", 32'(busy), 32'h0);

        // Fill past capacity with the consumer stalled, then drain.
        for (int r = 0; r < 9; r++) begin
            set_row(DW'(r * 16));
            step('1, 1'b0, 1'b0, 1'b0);
        end
        chk("fill_rowcnt", 32'(row_count), 32'd8);
        chk("fill_ovf",    32'(overflow), 32'h1F);
        got.delete();
        for (int i = 0; i < 60; i++) step('0, 1'b1, 1'b0, 1'b0);
        chk_rows("fill_word", 32'h0, 8);
        chk("fill_empty", 32'(row_count), 32'h0);
        step('0, 1'b0, 1'b1, 1'b0);
        chk("fill_clr_ovf", 32'(overflow), 32'h0);

        // Push into a full column on the same edge its head is popped.
        for (int r = 0; r < 8; r++) begin
            set_row(DW'(32'h200 + r * 16));
            step('1, 1'b0, 1'b0, 1'b0);
        end
        got.delete();
        din[0] = 32'hAAA;
        step(5'b00001, 1'b1, 1'b0, 1'b0);
        chk("pof_ovf",    32'(overflow), 32'h0);
        chk("pof_rowcnt", 32'(row_count), 32'd8);
        for (int i = 0; i < 60; i++) step('0, 1'b1, 1'b0, 1'b0);
        chk_rows("pof_word", 32'h200, 8);
        chk("pof_pending", 32'(busy), 32'h1);
        got.delete();
        set_row(32'hB00);
        step(5'b11110, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0, 1'b0);
        chk("pof_tail_cnt", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            chk("pof_tail0", got[0], 32'hAAA);
            for (int k = 1; k < 5; k++) chk("pof_tail", got[k], 32'hB00 + DW'(k));
        end
        chk("pof_done", 32'(busy), 32'h0);

        // Clear in the middle of a row.
        for (int r = 0; r < 3; r++) begin
            set_row(DW'(32'h400 + r * 16));
            step('1, 1'b0, 1'b0, 1'b0);
        end
        got.delete();
        step('0, 1'b1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
        chk("clr_pre_cnt", 32'(got.size()), 32'd2);
        step('0, 1'b1, 1'b1, 1'b0);
        chk("clr_valid",  32'(out_valid), 32'h0);
        chk("clr_rowcnt", 32'(row_count), 32'h0);
        chk("clr_ovf",    32'(overflow), 32'h0);
        chk("clr_busy",   32'(busy), 32'h0);
        got.delete();
        set_row(32'h300);
        step('1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step('0, 1'b1, 1'b0, 1'b0);
        chk_rows("clr_fresh", 32'h300, 1);

        // Random traffic: slow consumer first (overflows), then fast.
        for (int i = 0; i < 900; i++) begin
            for (int j = 0; j < COLS; j++) din[j] = $urandom;
            step(COLS'($urandom),
                 (i < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 149) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
